issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised, age-ordered reservation station for the out-of-order core. Holds up to DEPTH renamed instructions, wakes pending operands from NUM_CDB result-broadcast buses, and issues up to two ready instructions per cycle through two stallable valid/ready issue ports. Adds flush, back-pressure and same-cycle insert wakeup; sits between rename/dispatch and the ALU pair.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 5, producer tag width
- CTRL_W, 9, opaque control word width
- DEPTH, 8, entry count (≥2)
- NUM_CDB, 2, broadcast buses (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries and issue registers
- in_valid  in  1  insert request
- in_ready  out  1  ~full; count < DEPTH (registered state)
- in_ctrl / in_dest  in  CTRL_W / TAG_W  control word, destination tag
- in_s1_rdy, in_s2_rdy  in  1 each  operand value already available
- in_s1_tag, in_s2_tag  in  TAG_W each  producer tag when not ready
- in_s1_val, in_s2_val  in  DATA_W each  operand value when ready
- cdb_valid  in  NUM_CDB  per-bus broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  flattened tags, bus 0 in LSBs
- cdb_data  in  NUM_CDB*DATA_W  flattened results, bus 0 in LSBs
- issK_valid  out  1  (K=0,1) issue register holds an instruction
- issK_ready  in  1  downstream accepts this cycle
- issK_op1, issK_op2  out  DATA_W  operands
- issK_dest / issK_ctrl  out  TAG_W / CTRL_W
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry state: busy, s1/s2 ready bits, tags, values, ctrl, dest, age rank.
- Insert: fires when in_valid && in_ready; goes into lowest-index free entry. in_valid while !in_ready is ignored (no state change).
- Wakeup: each busy entry with a non-ready operand whose tag equals a valid cdb_tag captures that bus's data and sets ready. Multiple matching buses: lowest bus index wins. Ready operands never overwritten.
- Insert bypass: a non-ready incoming operand matching a valid CDB in the insert cycle is stored as ready with that data.
- Select: candidates = busy && s1 && s2 ready (registered state). Issue register K is loadable when !issK_valid or issK_ready. Port 0 takes the oldest candidate, port 1 the next oldest; if only port 1 loadable, it takes the oldest. Selected entries freed at same edge.
- Issue registers hold contents stable while valid && !ready; cleared to valid=0 on acceptance with nothing to reload.
- flush: all busy, issK_valid cleared at edge; overrides insert, wakeup, select that cycle.
- count = busy entries (excludes issue registers); in_ready derived from it.

## Timing
- Reset: all entries free, count=0, in_ready=1, issK_valid=0, issK_op1/op2/dest/ctrl=0.
- Insert with both operands ready (or bypassed) at edge N -> issK_valid earliest after edge N+1.
- CDB wakeup at edge N -> eligible for selection in cycle after N; issued after edge N+1.
- Freed slot is not reusable at the same edge; in_ready rises the cycle after.
- Full (count=DEPTH) with an issue at edge N: in_ready=1 in cycle N+1.
- Simultaneous insert and issue of different entries at one edge: both take effect; count updates net.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

## Configuration
- ISSUE_QUEUE_AGE_ORDER_EN defined: oldest-first selection via per-entry age rank (rank 0 = oldest; on insert rank = count, on free all younger ranks decrement).
- Undefined: no age tracking; port 0 takes lowest-index candidate, port 1 next-lowest index. All other behaviour identical.

## Test plan
- Reset, insert op1=5, op2=7 (both ready), dest=3, iss0_ready=1 -> iss0_valid=1 with op1=5, op2=7, dest=3 two edges after insert; count back to 0.
- Insert s1 tag=9 pending; drive cdb_valid=01, cdb_tag=9, data=0xAB next cycle -> issues with op1=0xAB one edge after broadcast.
- Insert with s2 tag=4 while cdb bus 1 broadcasts tag 4 data=0x11 same cycle -> entry issues with op2=0x11, no further broadcast needed.
- Fill DEPTH=8 entries, all ready, iss0_ready=iss1_ready=0 -> in_ready=0, iss0/iss1 hold first two (oldest) stable; raise both readies -> two issues per cycle in insertion order (with AGE_ORDER_EN).
- Both CDB buses carry tag 6 (data 1, 2) to a pending entry -> captured value 1.
- Queue holding 5 entries, valid issue registers, assert flush with in_valid=1 -> next cycle count=0, issK_valid=0, inserted instruction dropped.

Source files
------------

// File: rtl/issue_queue.sv
// issue_queue: reservation station with CDB wakeup, insert bypass and two stallable issue ports.
// Optional ISSUE_QUEUE_AGE_ORDER_EN: oldest-first selection by age rank; otherwise lowest index first.
module issue_queue #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned CTRL_W  = 9,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [TAG_W-1:0]            in_dest,
    input  logic                        in_s1_rdy,
    input  logic                        in_s2_rdy,
    input  logic [TAG_W-1:0]            in_s1_tag,
    input  logic [TAG_W-1:0]            in_s2_tag,
    input  logic [DATA_W-1:0]           in_s1_val,
    input  logic [DATA_W-1:0]           in_s2_val,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        iss0_valid,
    input  logic                        iss0_ready,
    output logic [DATA_W-1:0]           iss0_op1,
    output logic [DATA_W-1:0]           iss0_op2,
    output logic [TAG_W-1:0]            iss0_dest,
    output logic [CTRL_W-1:0]           iss0_ctrl,
    output logic                        iss1_valid,
    input  logic                        iss1_ready,
    output logic [DATA_W-1:0]           iss1_op1,
    output logic [DATA_W-1:0]           iss1_op2,
    output logic [TAG_W-1:0]            iss1_dest,
    output logic [CTRL_W-1:0]           iss1_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    typedef struct packed {
        opnd_t             s1;
        opnd_t             s2;
        logic [CTRL_W-1:0] ctrl;
        logic [TAG_W-1:0]  dest;
    } entry_t;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  dest;
        logic [CTRL_W-1:0] ctrl;
    } iss_t;

    // Capture a broadcast result into a pending operand; the lowest matching bus wins.
    function automatic opnd_t wake(input opnd_t o,
                                   input logic [NUM_CDB-1:0] cv,
                                   input logic [NUM_CDB*TAG_W-1:0] ct,
                                   input logic [NUM_CDB*DATA_W-1:0] cd);
        opnd_t r;
        logic  hit;
        r   = o;
        hit = o.rdy;
        for (int unsigned b = 0; b < NUM_CDB; b++) begin
            if (!hit && cv[b] && (ct[b*TAG_W +: TAG_W] == o.tag)) begin
                hit   = 1'b1;
                r.rdy = 1'b1;
                r.val = cd[b*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0] busy_q, busy_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic             iss0_valid_q, iss0_valid_d, iss1_valid_q, iss1_valid_d;
    iss_t             iss0_q, iss0_d, iss1_q, iss1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
    logic [IDX_W-1:0] age_q [DEPTH];
    logic [IDX_W-1:0] age_d [DEPTH];
`endif

    logic [DEPTH-1:0] cand;
    logic             pick_a_vld, pick_b_vld;
    logic [IDX_W-1:0] pick_a, pick_b;
    logic             load0, load1, sel0_vld, sel1_vld;
    logic [IDX_W-1:0] sel0, sel1;
    logic [DEPTH-1:0] free_vec;
    logic [CNT_W-1:0] n_free;
    logic             ins_fire, ins_found;
    logic [IDX_W-1:0] ins_idx;

    always_comb begin : candidates
        cand = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cand[i] = busy_q[i] & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
        end
    end

    // Rank candidates: pick_a is the first choice, pick_b the second.
    always_comb begin : pick
        pick_a_vld = 1'b0;
        pick_a     = '0;
        pick_b_vld = 1'b0;
        pick_b     = '0;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cand[i] && (!pick_a_vld || (age_q[i] < age_q[pick_a]))) begin
                pick_a_vld = 1'b1;
                pick_a     = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cand[i] && (IDX_W'(i) != pick_a) && (!pick_b_vld || (age_q[i] < age_q[pick_b]))) begin
                pick_b_vld = 1'b1;
                pick_b     = IDX_W'(i);
            end
        end
`else
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cand[i] && !pick_a_vld) begin
                pick_a_vld = 1'b1;
                pick_a     = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cand[i] && (IDX_W'(i) != pick_a) && !pick_b_vld) begin
                pick_b_vld = 1'b1;
                pick_b     = IDX_W'(i);
            end
        end
`endif
    end

    // Port 0 gets first choice when it can load; otherwise port 1 does.
    always_comb begin : route
        load0    = !iss0_valid_q || iss0_ready;
        load1    = !iss1_valid_q || iss1_ready;
        sel0_vld = load0 && pick_a_vld;
        sel0     = pick_a;
        sel1_vld = load0 ? (load1 && pick_b_vld) : (load1 && pick_a_vld);
        sel1     = load0 ? pick_b : pick_a;
        free_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            free_vec[i] = (sel0_vld && (sel0 == IDX_W'(i))) || (sel1_vld && (sel1 == IDX_W'(i)));
        end
        n_free = CNT_W'(sel0_vld) + CNT_W'(sel1_vld);
    end

    always_comb begin : ins_slot
        ins_fire  = in_valid && in_ready_q;
        ins_found = 1'b0;
        ins_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!ins_found && !busy_q[i]) begin
                ins_found = 1'b1;
                ins_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin : next_state
        busy_d       = busy_q;
        ent_d        = ent_q;
        iss0_valid_d = iss0_valid_q;
        iss1_valid_d = iss1_valid_q;
        iss0_d       = iss0_q;
        iss1_d       = iss1_q;
        count_d      = count_q;
        in_ready_d   = in_ready_q;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
        age_d        = age_q;
`endif
        if (flush) begin
            busy_d       = '0;
            iss0_valid_d = 1'b0;
            iss1_valid_d = 1'b0;
            count_d      = '0;
            in_ready_d   = 1'b1;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy_q[i]) begin
                    ent_d[i].s1 = wake(ent_q[i].s1, cdb_valid, cdb_tag, cdb_data);
                    ent_d[i].s2 = wake(ent_q[i].s2, cdb_valid, cdb_tag, cdb_data);
                end
            end
            if (load0) begin
                iss0_valid_d = sel0_vld;
                if (sel0_vld) begin
                    iss0_d.op1  = ent_q[sel0].s1.val;
                    iss0_d.op2  = ent_q[sel0].s2.val;
                    iss0_d.dest = ent_q[sel0].dest;
                    iss0_d.ctrl = ent_q[sel0].ctrl;
                end
            end
            if (load1) begin
                iss1_valid_d = sel1_vld;
                if (sel1_vld) begin
                    iss1_d.op1  = ent_q[sel1].s1.val;
                    iss1_d.op2  = ent_q[sel1].s2.val;
                    iss1_d.dest = ent_q[sel1].dest;
                    iss1_d.ctrl = ent_q[sel1].ctrl;
                end
            end
            busy_d = busy_q & ~free_vec;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
            // Survivors move up by the number of older entries issued this cycle.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_d[i] = age_q[i]
                         - IDX_W'(sel0_vld && (age_q[sel0] < age_q[i]))
                         - IDX_W'(sel1_vld && (age_q[sel1] < age_q[i]));
            end
`endif
            if (ins_fire) begin
                busy_d[ins_idx]      = 1'b1;
                ent_d[ins_idx].s1    = wake({in_s1_rdy, in_s1_tag, in_s1_val}, cdb_valid, cdb_tag, cdb_data);
                ent_d[ins_idx].s2    = wake({in_s2_rdy, in_s2_tag, in_s2_val}, cdb_valid, cdb_tag, cdb_data);
                ent_d[ins_idx].ctrl  = in_ctrl;
                ent_d[ins_idx].dest  = in_dest;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
                age_d[ins_idx]       = IDX_W'(count_q - n_free);
`endif
            end
            count_d    = count_q + CNT_W'(ins_fire) - n_free;
            in_ready_d = count_d < CNT_W'(DEPTH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin : regs
        if (!rst) begin
            busy_q       <= '0;
            iss0_valid_q <= 1'b0;
            iss1_valid_q <= 1'b0;
            iss0_q       <= '0;
            iss1_q       <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
                age_q[i] <= '0;
`endif
            end
        end else begin
            busy_q       <= busy_d;
            iss0_valid_q <= iss0_valid_d;
            iss1_valid_q <= iss1_valid_d;
            iss0_q       <= iss0_d;
            iss1_q       <= iss1_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            ent_q        <= ent_d;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
            age_q        <= age_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign count      = count_q;
    assign iss0_valid = iss0_valid_q;
    assign iss0_op1   = iss0_q.op1;
    assign iss0_op2   = iss0_q.op2;
    assign iss0_dest  = iss0_q.dest;
    assign iss0_ctrl  = iss0_q.ctrl;
    assign iss1_valid = iss1_valid_q;
    assign iss1_op1   = iss1_q.op1;
    assign iss1_op2   = iss1_q.op2;
    assign iss1_dest  = iss1_q.dest;
    assign iss1_ctrl  = iss1_q.ctrl;

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and random stimulus against a sequence-numbered slot model of issue_queue.
module tb_issue_queue;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned CTRL_W  = 9;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned NUM_CDB = 2;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [TAG_W-1:0]           in_dest;
    logic                       in_s1_rdy, in_s2_rdy;
    logic [TAG_W-1:0]           in_s1_tag, in_s2_tag;
    logic [DATA_W-1:0]          in_s1_val, in_s2_val;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]  cdb_data;
    logic                       iss0_valid, iss0_ready, iss1_valid, iss1_ready;
    logic [DATA_W-1:0]          iss0_op1, iss0_op2, iss1_op1, iss1_op2;
    logic [TAG_W-1:0]           iss0_dest, iss1_dest;
    logic [CTRL_W-1:0]          iss0_ctrl, iss1_ctrl;
    logic [CNT_W-1:0]           count;

    always #5 clk = ~clk;

    issue_queue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_dest(in_dest),
        .in_s1_rdy(in_s1_rdy), .in_s2_rdy(in_s2_rdy), .in_s1_tag(in_s1_tag), .in_s2_tag(in_s2_tag),
        .in_s1_val(in_s1_val), .in_s2_val(in_s2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss0_valid(iss0_valid), .iss0_ready(iss0_ready), .iss0_op1(iss0_op1), .iss0_op2(iss0_op2),
        .iss0_dest(iss0_dest), .iss0_ctrl(iss0_ctrl),
        .iss1_valid(iss1_valid), .iss1_ready(iss1_ready), .iss1_op1(iss1_op1), .iss1_op2(iss1_op2),
        .iss1_dest(iss1_dest), .iss1_ctrl(iss1_ctrl),
        .count(count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: slots with insertion sequence numbers; oldest = smallest sequence.
    bit                m_busy [DEPTH];
    int                m_seq  [DEPTH];
    bit                m_s1r  [DEPTH];
    bit                m_s2r  [DEPTH];
    logic [TAG_W-1:0]  m_s1t  [DEPTH];
    logic [TAG_W-1:0]  m_s2t  [DEPTH];
    logic [DATA_W-1:0] m_s1v  [DEPTH];
    logic [DATA_W-1:0] m_s2v  [DEPTH];
    logic [CTRL_W-1:0] m_ctrl [DEPTH];
    logic [TAG_W-1:0]  m_dest [DEPTH];
    bit                m_iv   [2];
    logic [DATA_W-1:0] m_iop1 [2];
    logic [DATA_W-1:0] m_iop2 [2];
    logic [TAG_W-1:0]  m_idest[2];
    logic [CTRL_W-1:0] m_ictrl[2];
    int                seq_ctr;

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_busy[i] = 0;
            m_seq[i]  = 0;
        end
        for (int k = 0; k < 2; k++) begin
            m_iv[k] = 0; m_iop1[k] = '0; m_iop2[k] = '0; m_idest[k] = '0; m_ictrl[k] = '0;
        end
        seq_ctr = 0;
    endtask

    function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        for (int b = 0; b < int'(NUM_CDB); b++) begin
            if (cdb_valid[b] && cdb_tag[b*TAG_W +: TAG_W] == t) begin
                d = cdb_data[b*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        d = '0;
        return 1'b0;
    endfunction

    function automatic int sel_key(input int i);
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
        return m_seq[i];
`else
        return i;
`endif
    endfunction

    function automatic bit is_cand(input int i);
        return m_busy[i] && m_s1r[i] && m_s2r[i];
    endfunction

    task automatic load_port(input int k, input int idx);
        if (idx < 0) begin
            m_iv[k] = 0;
        end else begin
            m_iv[k] = 1; m_iop1[k] = m_s1v[idx]; m_iop2[k] = m_s2v[idx];
            m_idest[k] = m_dest[idx]; m_ictrl[k] = m_ctrl[idx];
        end
    endtask

    task automatic model_step();
        int first, second, s0, s1, slot, nb;
        bit l0, l1;
        logic [DATA_W-1:0] d;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) m_busy[i] = 0;
            m_iv[0] = 0;
            m_iv[1] = 0;
            return;
        end
        nb = 0; slot = -1; first = -1; second = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (m_busy[i]) nb++;
            else if (slot < 0) slot = i;
        end
        for (int i = 0; i < int'(DEPTH); i++)
            if (is_cand(i) && (first < 0 || sel_key(i) < sel_key(first))) first = i;
        for (int i = 0; i < int'(DEPTH); i++)
            if (is_cand(i) && i != first && (second < 0 || sel_key(i) < sel_key(second))) second = i;
        l0 = !m_iv[0] || iss0_ready;
        l1 = !m_iv[1] || iss1_ready;
        s0 = -1; s1 = -1;
        if (l0) begin
            s0 = first;
            if (l1) s1 = second;
        end else if (l1) begin
            s1 = first;
        end
        if (l0) load_port(0, s0);
        if (l1) load_port(1, s1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (m_busy[i]) begin
                if (!m_s1r[i] && cdb_hit(m_s1t[i], d)) begin m_s1r[i] = 1; m_s1v[i] = d; end
                if (!m_s2r[i] && cdb_hit(m_s2t[i], d)) begin m_s2r[i] = 1; m_s2v[i] = d; end
            end
        end
        if (s0 >= 0) m_busy[s0] = 0;
        if (s1 >= 0) m_busy[s1] = 0;
        if (in_valid && nb < int'(DEPTH)) begin
            m_busy[slot] = 1; m_seq[slot] = seq_ctr; seq_ctr++;
            m_ctrl[slot] = in_ctrl; m_dest[slot] = in_dest;
            m_s1r[slot] = in_s1_rdy; m_s1t[slot] = in_s1_tag; m_s1v[slot] = in_s1_val;
            m_s2r[slot] = in_s2_rdy; m_s2t[slot] = in_s2_tag; m_s2v[slot] = in_s2_val;
            if (!in_s1_rdy && cdb_hit(in_s1_tag, d)) begin m_s1r[slot] = 1; m_s1v[slot] = d; end
            if (!in_s2_rdy && cdb_hit(in_s2_tag, d)) begin m_s2r[slot] = 1; m_s2v[slot] = d; end
        end
    endtask

    task automatic compare_all();
        int cnt;
        cnt = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (m_busy[i]) cnt++;
        check("count", 64'(count), 64'(cnt));
        check("in_ready", 64'(in_ready), 64'(cnt < int'(DEPTH)));
        check("iss0_valid", 64'(iss0_valid), 64'(m_iv[0]));
        if (m_iv[0]) begin
            check("iss0_op1", 64'(iss0_op1), 64'(m_iop1[0]));
            check("iss0_op2", 64'(iss0_op2), 64'(m_iop2[0]));
            check("iss0_dest", 64'(iss0_dest), 64'(m_idest[0]));
            check("iss0_ctrl", 64'(iss0_ctrl), 64'(m_ictrl[0]));
        end
        check("iss1_valid", 64'(iss1_valid), 64'(m_iv[1]));
        if (m_iv[1]) begin
            check("iss1_op1", 64'(iss1_op1), 64'(m_iop1[1]));
            check("iss1_op2", 64'(iss1_op2), 64'(m_iop2[1]));
            check("iss1_dest", 64'(iss1_dest), 64'(m_idest[1]));
            check("iss1_ctrl", 64'(iss1_ctrl), 64'(m_ictrl[1]));
        end
    endtask

    // One clock: inputs were set at the preceding negedge, outputs checked at the next.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; in_ctrl = '0; in_dest = '0;
        in_s1_rdy = 1; in_s2_rdy = 1; in_s1_tag = '0; in_s2_tag = '0; in_s1_val = '0; in_s2_val = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        iss0_ready = 1; iss1_ready = 1;
    endtask

    task automatic set_insert(input bit r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                              input bit r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2,
                              input logic [TAG_W-1:0] dst);
        in_valid = 1; in_ctrl = CTRL_W'(dst) + CTRL_W'(9'h40); in_dest = dst;
        in_s1_rdy = r1; in_s1_tag = t1; in_s1_val = v1;
        in_s2_rdy = r2; in_s2_tag = t2; in_s2_val = v2;
    endtask

    task automatic rand_inputs();
        flush     = ($urandom_range(0, 59) == 0);
        in_valid  = ($urandom_range(0, 9) < 6);
        in_ctrl   = CTRL_W'($urandom);
        in_dest   = TAG_W'($urandom);
        in_s1_rdy = ($urandom_range(0, 2) != 0);
        in_s2_rdy = ($urandom_range(0, 2) != 0);
        in_s1_tag = TAG_W'($urandom_range(0, 7));
        in_s2_tag = TAG_W'($urandom_range(0, 7));
        in_s1_val = $urandom;
        in_s2_val = $urandom;
        for (int b = 0; b < int'(NUM_CDB); b++) begin
            cdb_valid[b] = ($urandom_range(0, 2) == 0);
            cdb_tag[b*TAG_W +: TAG_W]   = TAG_W'($urandom_range(0, 7));
            cdb_data[b*DATA_W +: DATA_W] = $urandom;
        end
        iss0_ready = ($urandom_range(0, 9) < 7);
        iss1_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic async_reset();
        #2 rst = 0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_iss0_valid", 64'(iss0_valid), 64'd0);
        check("rst_iss1_valid", 64'(iss1_valid), 64'd0);
        check("rst_iss0_op1", 64'(iss0_op1), 64'd0);
        check("rst_iss1_op2", 64'(iss1_op2), 64'd0);
        check("rst_iss0_dest", 64'(iss0_dest), 64'd0);
        check("rst_iss1_ctrl", 64'(iss1_ctrl), 64'd0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1;
        @(negedge clk);
        async_reset();
        @(negedge clk);

        // Both operands ready: issue two edges after insert.
        set_insert(1, 5'd0, 32'd5, 1, 5'd0, 32'd7, 5'd3);
        tick();
        check("t1_count_after_insert", 64'(count), 64'd1);
        in_valid = 0;
        tick();
        check("t1_iss0_valid", 64'(iss0_valid), 64'd1);
        check("t1_iss0_op1", 64'(iss0_op1), 64'd5);
        check("t1_iss0_op2", 64'(iss0_op2), 64'd7);
        check("t1_iss0_dest", 64'(iss0_dest), 64'd3);
        check("t1_count", 64'(count), 64'd0);
        tick();

        // Pending s1 woken by bus 0.
        set_insert(0, 5'd9, 32'd0, 1, 5'd0, 32'd1, 5'd4);
        tick();
        in_valid = 0; cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd9}; cdb_data = {32'd0, 32'hAB};
        tick();
        check("t2_not_yet", 64'(iss0_valid), 64'd0);
        cdb_valid = '0;
        tick();
        check("t2_iss0_valid", 64'(iss0_valid), 64'd1);
        check("t2_iss0_op1", 64'(iss0_op1), 64'hAB);
        tick();

        // Insert bypass from bus 1.
        set_insert(1, 5'd0, 32'd2, 0, 5'd4, 32'd0, 5'd5);
        cdb_valid = 2'b10; cdb_tag = {5'd4, 5'd0}; cdb_data = {32'h11, 32'd0};
        tick();
        in_valid = 0; cdb_valid = '0;
        tick();
        check("t3_iss0_valid", 64'(iss0_valid), 64'd1);
        check("t3_iss0_op2", 64'(iss0_op2), 64'h11);
        tick();

        // Two buses match: bus 0 wins.
        set_insert(0, 5'd6, 32'd0, 1, 5'd0, 32'd3, 5'd6);
        tick();
        in_valid = 0; cdb_valid = 2'b11; cdb_tag = {5'd6, 5'd6}; cdb_data = {32'd2, 32'd1};
        tick();
        cdb_valid = '0;
        tick();
        check("t5_iss0_op1", 64'(iss0_op1), 64'd1);
        tick();

        // Fill with both ports stalled, then release.
        iss0_ready = 0; iss1_ready = 0;
        for (int i = 0; i < 10; i++) begin
            set_insert(1, 5'd0, 32'(i + 100), 1, 5'd0, 32'(i + 200), 5'(i));
            tick();
        end
        in_valid = 0;
        check("t4_count_full", 64'(count), 64'd8);
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        check("t4_iss0_oldest", 64'(iss0_dest), 64'd0);
        check("t4_iss1_next", 64'(iss1_dest), 64'd1);
        tick();
        check("t4_iss0_stable", 64'(iss0_dest), 64'd0);
        set_insert(1, 5'd0, 32'd1, 1, 5'd0, 32'd1, 5'd20);
        tick();
        check("t4_full_ignored", 64'(count), 64'd8);
        in_valid = 0; iss0_ready = 1; iss1_ready = 1;
        tick();
        check("t4_count_after_issue", 64'(count), 64'd6);
        check("t4_in_ready_back", 64'(in_ready), 64'd1);
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
        check("t4_age_iss0", 64'(iss0_dest), 64'd2);
        check("t4_age_iss1", 64'(iss1_dest), 64'd3);
`endif
        tick();
        async_reset();

        // Flush with 5 queued entries and both issue registers valid.
        iss0_ready = 0; iss1_ready = 0;
        for (int i = 0; i < 7; i++) begin
            set_insert(1, 5'd0, 32'(i), 1, 5'd0, 32'(i), 5'(i));
            tick();
        end
        check("t6_count_pre", 64'(count), 64'd5);
        flush = 1;
        set_insert(1, 5'd0, 32'd9, 1, 5'd0, 32'd9, 5'd9);
        tick();
        check("t6_count", 64'(count), 64'd0);
        check("t6_iss0_valid", 64'(iss0_valid), 64'd0);
        check("t6_iss1_valid", 64'(iss1_valid), 64'd0);
        flush = 0; in_valid = 0; iss0_ready = 1; iss1_ready = 1;
        tick();
        check("t6_dropped", 64'(count), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            tick();
            if (c == 1500) async_reset();
        end
        clear_inputs();
        for (int c = 0; c < 12; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
